// File: rtl/pwe_pkg.sv
// Shared definitions for the pulse-width-engine channel scheduler.
package pwe_pkg;

  // Default channel count and duty word width.
  localparam int unsigned PWE_NUM_CH  = 4;
  localparam int unsigned PWE_DW      = 8;

  // WAIT cycles allowed without eng_done before the job is abandoned.
  localparam int unsigned PWE_TIMEOUT = 255;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StNext
  } pwe_state_e;

  // Index width for a given channel count (never zero).
  function automatic int unsigned pwe_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pwe_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or after ptr,
// wrapping past NUM_CH-1 back to 0.
module pwe_rr_pick
  import pwe_pkg::*;
#(
  parameter int unsigned NUM_CH = PWE_NUM_CH,
  localparam int unsigned CW    = pwe_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [CW-1:0]     ptr,
  output logic              found,
  output logic [CW-1:0]     sel
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the closest eligible channel wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned off = NUM_CH; off > 0; off--) begin
      idx = (32'(ptr) + off - 1) % NUM_CH;
      if (elig[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/pwe_chan_sched.sv
// Channel scheduler for a shared pulse-width engine: holds per-channel duty
// words, picks channels round-robin and hands one job at a time to the engine.
// Optional build macro: PWE_SCHED_TIMEOUT_EN (abandon a job after PWE_TIMEOUT
// WAIT cycles without eng_done and raise the sticky err flag).
module pwe_chan_sched
  import pwe_pkg::*;
#(
  parameter int unsigned NUM_CH = PWE_NUM_CH,
  parameter int unsigned DW     = PWE_DW,
  localparam int unsigned CW    = pwe_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_addr,
  input  logic [DW-1:0]     cfg_data,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              eng_start,
  output logic [DW-1:0]     eng_duty,
  output logic [CW-1:0]     eng_ch,
  input  logic              eng_done,
  output logic              busy,
  output logic              err
);

  pwe_state_e        state_q, state_d;
  logic [DW-1:0]     duty_q [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     ptr_adv;
  logic [CW-1:0]     pick_ptr;
  logic              found;
  logic [CW-1:0]     sel;
  logic              load_job;
  logic [CW-1:0]     job_ch_q;
  logic [DW-1:0]     job_duty_q;

  // Duty register file; writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_addr == CW'(i))) begin
          duty_q[i] <= cfg_data;
        end
      end
    end
  end

  // A channel is eligible when enabled and programmed with a non-zero duty.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_en[i] && (duty_q[i] != '0);
    end
  end

  // Channel after the one just served, wrapping at NUM_CH.
  assign ptr_adv = (job_ch_q == CW'(NUM_CH - 1)) ? '0 : job_ch_q + 1'b1;

  // In NEXT the pointer register has not moved yet, so pick from the advanced value.
  assign pick_ptr = (state_q == StNext) ? ptr_adv : ptr_q;

  pwe_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .elig  (elig),
    .ptr   (pick_ptr),
    .found (found),
    .sel   (sel)
  );

`ifdef PWE_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(PWE_TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          timeout;
  logic          err_q;

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == StWait) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Last allowed WAIT cycle passed without eng_done; a real done wins.
  assign timeout = (state_q == StWait) && !eng_done &&
                   (wait_cnt_q == TW'(PWE_TIMEOUT - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state, pointer advance and job-latch decisions.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    load_job = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ena && found) begin
          state_d  = StIssue;
          load_job = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (eng_done) begin
          state_d = StNext;
        end
`ifdef PWE_SCHED_TIMEOUT_EN
        else if (timeout) begin
          state_d = StNext;
        end
`endif
      end
      StNext: begin
        ptr_d = ptr_adv;
        if (ena && found) begin
          state_d  = StIssue;
          load_job = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Latched job copy so later duty writes cannot disturb the job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_ch_q   <= '0;
      job_duty_q <= '0;
    end else if (load_job) begin
      job_ch_q   <= sel;
      job_duty_q <= duty_q[sel];
    end
  end

  assign eng_start = (state_q == StIssue);
  assign busy      = (state_q == StIssue) || (state_q == StWait);
  assign eng_duty  = job_duty_q;
  assign eng_ch    = job_ch_q;

endmodule

// File: tb/tb_pwe_chan_sched.sv
// Directed bench for pwe_chan_sched: expected jobs are queued as stimulus is
// set up and checked against each eng_start pulse, including issue spacing.
module tb_pwe_chan_sched;
  import pwe_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              cfg_we;
  logic [CW-1:0]     cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic [NUM_CH-1:0] ch_en;
  logic              eng_start;
  logic [DW-1:0]     eng_duty;
  logic [CW-1:0]     eng_ch;
  logic              eng_done;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  pwe_chan_sched #(
    .NUM_CH (NUM_CH),
    .DW     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .ch_en     (ch_en),
    .eng_start (eng_start),
    .eng_duty  (eng_duty),
    .eng_ch    (eng_ch),
    .eng_done  (eng_done),
    .busy      (busy),
    .err       (err)
  );

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] duty;
  } job_t;

  job_t exp_q[$];
  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   cyc        = 0;
  int   prev_cyc   = -1;
  int   done_delay = 0;
  int   cd         = 0;
  int   exp_gap    = 0;
  logic force_done = 1'b0;
  logic saw_start  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, answer the engine, score any issue.
  task automatic tick();
    job_t j;
    @(negedge clk);
    cyc++;
    saw_start = eng_start;
    eng_done  = force_done;
    if (cd > 0) begin
      cd--;
      if (cd == 0) eng_done = 1'b1;
    end
    if (eng_start === 1'b1) begin
      check("issue_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        j = exp_q.pop_front();
        check("eng_ch", 32'(eng_ch), 32'(j.ch));
        check("eng_duty", 32'(eng_duty), 32'(j.duty));
      end
      if (prev_cyc >= 0 && exp_gap > 0) check("issue_gap", cyc - prev_cyc, exp_gap);
      prev_cyc = cyc;
      check("busy_in_issue", 32'(busy), 1);
      if (done_delay > 0) cd = done_delay;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    ch_en      = '0;
    force_done = 1'b0;
    eng_done   = 1'b0;
    cd         = 0;
    done_delay = 0;
    exp_gap    = 0;
    prev_cyc   = -1;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    saw_start = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = CW'(a);
    cfg_data = DW'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic push(input int ch, input int d);
    job_t j;
    j.ch   = CW'(ch);
    j.duty = DW'(d);
    exp_q.push_back(j);
  endtask

  task automatic wait_empty(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_start_on(input logic [CW-1:0] ch, input string tag);
    int n = 0;
    while (!(saw_start && eng_ch == ch) && n < 80) begin
      tick();
      n++;
    end
    check(tag, 32'(saw_start && eng_ch == ch), 1);
  endtask

  // Consume all expected issues, drop ena and let the last job finish.
  task automatic drain(input string tag);
    int n = 0;
    wait_empty(tag, 400);
    ena = 1'b0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("busy_after_drain", 32'(busy), 0);
  endtask

  initial begin
    do_reset();
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_eng_duty", 32'(eng_duty), 0);
    check("rst_eng_ch", 32'(eng_ch), 0);

    // Single channel, done six cycles into the job: one issue every 8 cycles.
    wr(0, 'h40);
    ch_en      = 4'b0001;
    done_delay = 6;
    exp_gap    = 8;
    for (int i = 0; i < 4; i++) push(0, 'h40);
    ena = 1'b1;
    drain("single_ch_pending");

    // Four channels, immediate done: strict rotation, 3 cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 10 * (i + 1));
    ch_en      = 4'b1111;
    done_delay = 1;
    exp_gap    = 3;
    push(0, 10); push(1, 20); push(2, 30); push(3, 40); push(0, 10);
    ena = 1'b1;
    drain("rotate_pending");

    // Zero duty on ch2: it is skipped.
    do_reset();
    wr(0, 10); wr(1, 20); wr(2, 0); wr(3, 40);
    ch_en      = 4'b1111;
    done_delay = 1;
    exp_gap    = 3;
    push(0, 10); push(1, 20); push(3, 40); push(0, 10); push(1, 20);
    ena = 1'b1;
    drain("skip_zero_pending");

    // Nothing eligible: stays idle with ena high.
    ch_en = 4'b0000;
    ena   = 1'b1;
    repeat (10) tick();
    check("idle_no_enable", 32'(busy), 0);
    ch_en = 4'b0100;
    repeat (10) tick();
    check("idle_zero_duty", 32'(busy), 0);
    ena = 1'b0;

    // Duty write during ch1's WAIT applies only from its next issue.
    do_reset();
    wr(0, 'h11); wr(1, 'h22);
    ch_en      = 4'b0011;
    done_delay = 10;
    exp_gap    = 12;
    push(0, 'h11); push(1, 'h22); push(0, 'h11); push(1, 'h99);
    ena = 1'b1;
    wait_start_on(2'd1, "ch1_first_issue");
    tick();
    wr(1, 'h99);
    drain("late_write_pending");

    // Disabling ch1 mid-job lets it finish; afterwards it is skipped.
    do_reset();
    wr(0, 1); wr(1, 2); wr(2, 3);
    ch_en      = 4'b0111;
    done_delay = 4;
    exp_gap    = 6;
    push(0, 1); push(1, 2); push(2, 3); push(0, 1); push(2, 3);
    ena = 1'b1;
    wait_start_on(2'd1, "ch1_issue_before_disable");
    tick();
    ch_en = 4'b0101;
    drain("disable_pending");

    // Asynchronous reset in WAIT; a late done must not restart anything.
    do_reset();
    wr(0, 5); wr(1, 6);
    ch_en = 4'b0011;
    push(0, 5);
    ena = 1'b1;
    wait_empty("pre_reset_pending", 20);
    tick();
    tick();
    check("busy_in_wait", 32'(busy), 1);
    #2 rst_n = 1'b0;
    ena = 1'b0;
    #1;
    check("mid_rst_eng_start", 32'(eng_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_eng_duty", 32'(eng_duty), 0);
    check("mid_rst_eng_ch", 32'(eng_ch), 0);
    check("mid_rst_err", 32'(err), 0);
    tick();
    rst_n      = 1'b1;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    check("late_done_ignored", 32'(busy), 0);
    prev_cyc   = -1;
    wr(1, 7); wr(0, 8);
    done_delay = 1;
    exp_gap    = 3;
    push(0, 8); push(1, 7);
    ena = 1'b1;
    drain("post_reset_pending");

    // Engine never answers.
    do_reset();
    wr(0, 1); wr(1, 2);
    ch_en = 4'b0011;
`ifdef PWE_SCHED_TIMEOUT_EN
    exp_gap = 1 + PWE_TIMEOUT + 1;
    push(0, 1); push(1, 2);
    ena = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() == 2 && n < 20) begin
        tick();
        n++;
      end
    end
    check("err_before_timeout", 32'(err), 0);
    wait_empty("timeout_pending", 400);
    check("err_after_timeout", 32'(err), 1);
    drain("timeout_drain");
    check("err_sticky", 32'(err), 1);
`else
    push(0, 1);
    ena = 1'b1;
    wait_empty("hold_pending", 20);
    repeat (300) tick();
    check("busy_held", 32'(busy), 1);
    check("err_tied_low", 32'(err), 0);
    ena = 1'b0;
`endif
    do_reset();
    check("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
